leaf_out_arbiter: RTL



---
 rtl/leaf_out_arbiter.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter
//
// Round-robin arbiter sharing the single leaf-to-BFT egress path between the
// user kernel's output streams. Each accepted 32-bit word is wrapped into one
// BFT packet {valid, dest_leaf, dest_port, seq, payload} using a per-port
// destination table, and held in a one-entry output register until the leaf
// interface takes it.
//
// Optional feature macro: LEAF_ARB_CREDIT_EN
//   defined   - per-port freespace credit counters gate eligibility so a source
//               cannot overrun the remote input buffer.
//   undefined - no credit logic; fs_upd_vld / fs_upd_port are ignored.
//
// Ports
//   clk_user       in   user clock, all logic on the rising edge
//   reset_n        in   synchronous active-low reset
//   din_user       in   NUM_OUT_PORTS*PAYLOAD_BITS, port i in slice i
//   vld_user       in   ap_vld per port
//   ack_user       out  ap_ack per port, combinational, one-hot or zero
//   cfg_we         in   destination table write strobe
//   cfg_port       in   table entry written
//   cfg_dest_leaf  in   destination leaf for the written entry
//   cfg_dest_port  in   destination port for the written entry
//   fs_upd_vld     in   freespace update strobe
//   fs_upd_port    in   port whose credits are returned
//   pkt_out        out  packet to the leaf interface
//   pkt_vld        out  pkt_out valid
//   pkt_rdy        in   leaf interface accepts pkt_out

module leaf_out_arbiter #(
    parameter int unsigned NUM_OUT_PORTS         = 2,
    parameter int unsigned PAYLOAD_BITS          = 32,
    parameter int unsigned NUM_LEAF_BITS         = 5,
    parameter int unsigned NUM_PORT_BITS         = 4,
    parameter int unsigned NUM_ADDR_BITS         = 7,
    parameter int unsigned NUM_BRAM_ADDR_BITS    = 7,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
    parameter int unsigned PACKET_BITS           = 49,
    localparam int unsigned PORT_SEL_BITS =
        (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1
) (
    input  logic                                  clk_user,
    input  logic                                  reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user,
    output logic [NUM_OUT_PORTS-1:0]              ack_user,
    input  logic                                  cfg_we,
    input  logic [PORT_SEL_BITS-1:0]              cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
    input  logic                                  fs_upd_vld,
    input  logic [PORT_SEL_BITS-1:0]              fs_upd_port,
    output logic [PACKET_BITS-1:0]                pkt_out,
    output logic                                  pkt_vld,
    input  logic                                  pkt_rdy
);

    // ------------------------------------------------------------------
    // Output register state machine
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } out_state_e;

    out_state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Per-port state
    // ------------------------------------------------------------------
    logic [NUM_OUT_PORTS-1:0] cfg_valid_q, cfg_valid_d;
    logic [NUM_LEAF_BITS-1:0] dest_leaf_q [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] dest_leaf_d [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dest_port_q [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dest_port_d [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_q       [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_d       [NUM_OUT_PORTS];

    logic [PAYLOAD_BITS-1:0]  din_word    [NUM_OUT_PORTS];

    logic [PORT_SEL_BITS-1:0] last_grant_q, last_grant_d;
    logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

    logic [NUM_OUT_PORTS-1:0] eligible;
    logic                     grant_found;
    logic [PORT_SEL_BITS-1:0] grant_idx;
    logic                     can_capture;
    logic                     capture;

    // Split the flat input bus into per-port words.
    for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_din_split
        assign din_word[gi] = din_user[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

`ifdef LEAF_ARB_CREDIT_EN
    // ------------------------------------------------------------------
    // Freespace credits: one counter per port, full at reset.
    // ------------------------------------------------------------------
    localparam int unsigned CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
    localparam int unsigned CREDIT_MAX  = 2 ** NUM_BRAM_ADDR_BITS;

    logic [CREDIT_BITS-1:0] credit_q [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0] credit_d [NUM_OUT_PORTS];
    int unsigned            credit_sum;

    always_comb begin
        credit_sum = 0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            // Grant and update on the same port fold into one net adjustment;
            // the grant only happens with credit > 0, so the sum never wraps.
            credit_sum = 32'(credit_q[i]);
            if (fs_upd_vld && (fs_upd_port == PORT_SEL_BITS'(i))) begin
                credit_sum = credit_sum + FREESPACE_UPDATE_SIZE;
            end
            if (capture && (grant_idx == PORT_SEL_BITS'(i))) begin
                credit_sum = credit_sum - 1;
            end
            if (credit_sum > CREDIT_MAX) begin
                credit_sum = CREDIT_MAX;
            end
            credit_d[i] = CREDIT_BITS'(credit_sum);
        end
    end

    always_ff @(posedge clk_user) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= CREDIT_BITS'(CREDIT_MAX);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user[i] & cfg_valid_q[i] & (credit_q[i] != '0);
        end
    end
`else
    // Credit inputs and sizing parameters have no effect in this build.
    logic unused_credit_inputs;
    assign unused_credit_inputs = ^{fs_upd_vld, fs_upd_port,
                                    NUM_BRAM_ADDR_BITS[0], FREESPACE_UPDATE_SIZE[0]};

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user[i] & cfg_valid_q[i];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Round-robin search starting one past the last winner.
    // ------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
            logic [PORT_SEL_BITS-1:0] idx;
            idx = PORT_SEL_BITS'((32'(last_grant_q) + 32'd1 + k) % NUM_OUT_PORTS);
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // The output register can take a new packet when empty or being drained.
    // Gating with reset_n keeps words from being acked while reset is held.
    assign can_capture = (state_q == StEmpty) || pkt_rdy;
    assign capture     = reset_n && can_capture && grant_found;

    always_comb begin
        ack_user = '0;
        if (capture) begin
            ack_user[grant_idx] = 1'b1;
        end
    end

    assign last_grant_d = capture ? grant_idx : last_grant_q;

    // ------------------------------------------------------------------
    // Packet build: registered table contents are used, so a same-cycle
    // table write only affects later packets.
    // ------------------------------------------------------------------
    always_comb begin
        pkt_d = pkt_q;
        if (capture) begin
            pkt_d = {1'b1,
                     dest_leaf_q[grant_idx],
                     dest_port_q[grant_idx],
                     seq_q[grant_idx],
                     din_word[grant_idx]};
        end
    end

    // ------------------------------------------------------------------
    // Destination table and sequence counters
    // ------------------------------------------------------------------
    always_comb begin
        cfg_valid_d = cfg_valid_q;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            dest_leaf_d[i] = dest_leaf_q[i];
            dest_port_d[i] = dest_port_q[i];
            seq_d[i]       = seq_q[i];
            if (cfg_we && (cfg_port == PORT_SEL_BITS'(i))) begin
                cfg_valid_d[i] = 1'b1;
                dest_leaf_d[i] = cfg_dest_leaf;
                dest_port_d[i] = cfg_dest_port;
            end
            // Natural wrap at 2^NUM_ADDR_BITS.
            if (capture && (grant_idx == PORT_SEL_BITS'(i))) begin
                seq_d[i] = seq_q[i] + NUM_ADDR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_user) begin
        if (!reset_n) begin
            cfg_valid_q  <= '0;
            last_grant_q <= PORT_SEL_BITS'(NUM_OUT_PORTS - 1);
            pkt_q        <= '0;
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                dest_leaf_q[i] <= '0;
                dest_port_q[i] <= '0;
                seq_q[i]       <= '0;
            end
        end else begin
            cfg_valid_q  <= cfg_valid_d;
            last_grant_q <= last_grant_d;
            pkt_q        <= pkt_d;
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                dest_leaf_q[i] <= dest_leaf_d[i];
                dest_port_q[i] <= dest_port_d[i];
                seq_q[i]       <= seq_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_user) begin
        if (!reset_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: begin
                if (capture) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                // A capture alongside pkt_rdy refills the register back-to-back.
                if (pkt_rdy && !capture) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    assign pkt_vld = (state_q == StFull);
    assign pkt_out = pkt_q;

endmodule
